uart_reg_master: RTL and testbench
==================================

// Module: uart_reg_master
// PURPOSE
//  Initiator side of the game's 32 x 8-bit register port (write_en/read_en/addr/data). Turns a UART
//  byte stream from the host into single-cycle register writes and reads. Read results return as a
//  UART byte. Sits between the UART RX/TX blocks and Frogger_Game's register interface.
// PARAMETERS
//  ADDR_WIDTH      5           register address width (32 entries)
//  DATA_WIDTH      8           register data width
//  C_READ_LATENCY  1           cycles from o_read_en high to i_read_data valid (>=1)
//  C_TIMEOUT       25_000_000  max idle cycles between command byte and data byte of a write
// PORTS
//  i_Clk           in   1           system clock
//  i_Reset         in   1           synchronous, active-high reset
//  i_RX_DV         in   1           one-cycle strobe: i_RX_Byte valid
//  i_RX_Byte       in   8           received byte
//  i_TX_Active     in   1           UART TX busy
//  o_TX_DV         out  1           one-cycle strobe: send o_TX_Byte
//  o_TX_Byte       out  8           byte to transmit (read response)
//  o_write_en      out  1           register write strobe
//  o_write_addr    out  ADDR_WIDTH  write address
//  o_write_data    out  DATA_WIDTH  write data
//  o_read_en       out  1           register read strobe
//  o_read_addr     out  ADDR_WIDTH  read address
//  i_read_data     in   DATA_WIDTH  read data, valid C_READ_LATENCY cycles after o_read_en
//  o_Busy          out  1           high whenever state != IDLE
//  o_Error         out  1           one-cycle pulse on protocol error or timeout
// BEHAVIOUR
//  - Command byte: bit7 = 1 write / 0 read; bits6:5 must be 00; bits4:0 = address.
//  - Write = command byte, then data byte. Read = command byte only; response = 1 byte on TX.
//  - All outputs are registered. On i_Reset: every output = 0, state = IDLE, counters = 0.
//    Reset mid-transaction aborts it with no strobe and no error pulse.
//  - States: IDLE, WAIT_DATA, WRITE, READ_REQ, READ_WAIT, TX_SEND.
//  - IDLE, i_RX_DV at cycle N:
//    - bits6:5 != 00: stay IDLE, o_Error = 1 in cycle N+1.
//    - Write cmd: latch o_write_addr, clear timeout counter, go to WAIT_DATA.
//    - Read cmd: latch o_read_addr, go to READ_REQ (o_read_en = 1 in cycle N+1 only).
//  - WAIT_DATA:
//    - i_RX_DV at cycle M: latch o_write_data, go to WRITE. o_write_en = 1 in cycle M+1 only,
//      with addr/data stable. Then IDLE.
//    - Timeout counter reaching C_TIMEOUT-1 without i_RX_DV: go to IDLE, o_Error pulse, no write.
//  - READ_WAIT:
//    - Counts C_READ_LATENCY cycles after o_read_en, then captures i_read_data into o_TX_Byte.
//    - Goes to TX_SEND.
//  - TX_SEND:
//    - While i_TX_Active = 1: wait.
//    - First cycle with i_TX_Active = 0: o_TX_DV = 1 for exactly one cycle, then IDLE.
//    - o_TX_Byte holds its value until the next read capture.
//  - i_RX_DV in READ_REQ/READ_WAIT/TX_SEND/WRITE: byte dropped, o_Error pulse, state unaffected.
//  - o_write_en and o_read_en are never high in the same cycle. Each is at most 1 cycle per transaction.
//  - Address bits above ADDR_WIDTH are ignored. No wrap-around issue; the address is taken verbatim.
//  - Timeout counter is $clog2(C_TIMEOUT) bits wide and saturates; it is only active in WAIT_DATA.
// TESTING
//  1. RX 0x83 then 0x5A -> exactly one o_write_en pulse, addr=3, data=0x5A, one cycle after 2nd DV.
//  2. RX 0x07, model returns 0xC3 after 1 cycle -> o_read_en pulse with addr=7; o_TX_DV pulse with
//     o_TX_Byte=0xC3.
//  3. RX 0x07 with i_TX_Active held high 50 cycles -> o_TX_DV waits; asserts the cycle Active drops.
//  4. RX 0xA1 (bits6:5=01) -> o_Error 1-cycle pulse; no strobes; o_Busy stays 0.
//  5. C_TIMEOUT=16: RX 0x82, no data byte -> o_Error at cycle 16 after cmd, back to IDLE. Later
//     0x82, 0x11 writes normally.
//  6. i_Reset asserted in WAIT_DATA -> all outputs 0 next cycle; following data byte causes no write.

Source files
------------

// File: rtl/uart_reg_master_if.sv
// Bundle of the UART byte stream and the 32 x 8 register port seen by uart_reg_master.
// master = the bridge itself, slave = the UART blocks plus the register file it drives.
interface uart_reg_master_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8
);
  // Every *_DV / *_en signal is a one-cycle strobe: its payload is valid only in that cycle.
  // There is no ready, so the receiver must take it then. i_TX_Active is the only back-pressure:
  // o_TX_DV is never raised while it is high.
  logic                  i_RX_DV;
  logic [7:0]            i_RX_Byte;
  logic                  i_TX_Active;
  logic                  o_TX_DV;
  logic [7:0]            o_TX_Byte;
  logic                  o_write_en;
  logic [ADDR_WIDTH-1:0] o_write_addr;
  logic [DATA_WIDTH-1:0] o_write_data;
  logic                  o_read_en;
  logic [ADDR_WIDTH-1:0] o_read_addr;
  logic [DATA_WIDTH-1:0] i_read_data;
  logic                  o_Busy;
  logic                  o_Error;

  modport master (
    input  i_RX_DV, i_RX_Byte, i_TX_Active, i_read_data,
    output o_TX_DV, o_TX_Byte, o_write_en, o_write_addr, o_write_data,
    output o_read_en, o_read_addr, o_Busy, o_Error
  );

  modport slave (
    output i_RX_DV, i_RX_Byte, i_TX_Active, i_read_data,
    input  o_TX_DV, o_TX_Byte, o_write_en, o_write_addr, o_write_data,
    input  o_read_en, o_read_addr, o_Busy, o_Error
  );
endinterface

// File: rtl/uart_reg_master.sv
// Bridges a host UART byte stream onto the game's register port: one command byte
// (plus a data byte for writes) becomes a single-cycle write or a read answered over TX.
module uart_reg_master #(
  parameter int ADDR_WIDTH     = 5,
  parameter int DATA_WIDTH     = 8,
  parameter int C_READ_LATENCY = 1,
  parameter int C_TIMEOUT      = 25_000_000
) (
  input  logic                     i_Clk,
  input  logic                     i_Reset,
  uart_reg_master_if.master        bus,
  output logic [2:0]               o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_DATA = 3'd1,
    S_WRITE     = 3'd2,
    S_READ_REQ  = 3'd3,
    S_READ_WAIT = 3'd4,
    S_TX_SEND   = 3'd5
  } state_t;

  localparam int CNT_W = $clog2(C_TIMEOUT);
  localparam int LAT_W = $clog2(C_READ_LATENCY + 1);
  // Seeing this count with no byte means the next count would be C_TIMEOUT-1: give up.
  localparam logic [CNT_W-1:0] C_TO_LAST  = CNT_W'(C_TIMEOUT - 2);
  localparam logic [LAT_W-1:0] C_LAT_LAST = LAT_W'(C_READ_LATENCY - 1);

  state_t                r_state;
  state_t                w_next;
  logic [CNT_W-1:0]      r_to_cnt;
  logic [CNT_W-1:0]      w_to_inc;
  logic [LAT_W-1:0]      r_lat_cnt;
  logic                  w_err;
  logic                  w_latch_waddr;
  logic                  w_latch_raddr;
  logic                  w_latch_wdata;
  logic                  w_capture;
  logic                  w_tx_fire;

  logic                  r_tx_dv;
  logic [7:0]            r_tx_byte;
  logic                  r_write_en;
  logic [ADDR_WIDTH-1:0] r_write_addr;
  logic [DATA_WIDTH-1:0] r_write_data;
  logic                  r_read_en;
  logic [ADDR_WIDTH-1:0] r_read_addr;
  logic                  r_busy;
  logic                  r_error;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    w_err         = 1'b0;
    w_latch_waddr = 1'b0;
    w_latch_raddr = 1'b0;
    w_latch_wdata = 1'b0;
    w_capture     = 1'b0;
    w_tx_fire     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.i_RX_DV) begin
          if (bus.i_RX_Byte[6:5] != 2'b00) begin
            w_err = 1'b1;
          end else if (bus.i_RX_Byte[7]) begin
            w_next        = S_WAIT_DATA;
            w_latch_waddr = 1'b1;
          end else begin
            w_next        = S_READ_REQ;
            w_latch_raddr = 1'b1;
          end
        end
      end
      S_WAIT_DATA: begin
        if (bus.i_RX_DV) begin
          w_next        = S_WRITE;
          w_latch_wdata = 1'b1;
        end else if (r_to_cnt == C_TO_LAST) begin
          w_next = S_IDLE;
          w_err  = 1'b1;
        end
      end
      S_WRITE: begin
        w_next = S_IDLE;
        w_err  = bus.i_RX_DV;
      end
      S_READ_REQ: begin
        w_next = S_READ_WAIT;
        w_err  = bus.i_RX_DV;
      end
      S_READ_WAIT: begin
        w_err = bus.i_RX_DV;
        if (r_lat_cnt == C_LAT_LAST) begin
          w_capture = 1'b1;
          w_next    = S_TX_SEND;
        end
      end
      S_TX_SEND: begin
        w_err = bus.i_RX_DV;
        if (!bus.i_TX_Active) begin
          w_tx_fire = 1'b1;
          w_next    = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_to_inc = (r_to_cnt == '1) ? r_to_cnt : r_to_cnt + 1'b1;

  // Outputs are computed from the next state so they line up with the state they describe.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_to_cnt     <= '0;
      r_lat_cnt    <= '0;
      r_tx_dv      <= 1'b0;
      r_tx_byte    <= '0;
      r_write_en   <= 1'b0;
      r_write_addr <= '0;
      r_write_data <= '0;
      r_read_en    <= 1'b0;
      r_read_addr  <= '0;
      r_busy       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_to_cnt   <= (r_state == S_WAIT_DATA && w_next == S_WAIT_DATA) ? w_to_inc : '0;
      r_lat_cnt  <= (r_state == S_READ_WAIT && !w_capture) ? r_lat_cnt + 1'b1 : '0;
      r_tx_dv    <= w_tx_fire;
      r_write_en <= w_latch_wdata;
      r_read_en  <= w_latch_raddr;
      r_busy     <= (w_next != S_IDLE);
      r_error    <= w_err;
      if (w_latch_waddr) r_write_addr <= bus.i_RX_Byte[ADDR_WIDTH-1:0];
      if (w_latch_raddr) r_read_addr  <= bus.i_RX_Byte[ADDR_WIDTH-1:0];
      if (w_latch_wdata) r_write_data <= DATA_WIDTH'(bus.i_RX_Byte);
      if (w_capture)     r_tx_byte    <= 8'(bus.i_read_data);
    end
  end

  assign bus.o_TX_DV      = r_tx_dv;
  assign bus.o_TX_Byte    = r_tx_byte;
  assign bus.o_write_en   = r_write_en;
  assign bus.o_write_addr = r_write_addr;
  assign bus.o_write_data = r_write_data;
  assign bus.o_read_en    = r_read_en;
  assign bus.o_read_addr  = r_read_addr;
  assign bus.o_Busy       = r_busy;
  assign bus.o_Error      = r_error;
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_uart_reg_master.sv
// Directed bench for uart_reg_master: writes, reads, TX back-pressure, bad commands,
// write timeout and reset abort, with strobes checked against an expected-transaction queue.
module tb_uart_reg_master;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  logic [12:0] exp_wr_q[$];
  logic [4:0]  exp_rd_q[$];
  logic [7:0]  exp_tx_q[$];

  logic [7:0]  mem [32];
  logic [4:0]  r_rd_addr = '0;

  uart_reg_master_if #(.ADDR_WIDTH(5), .DATA_WIDTH(8)) bus ();

  uart_reg_master #(
    .ADDR_WIDTH(5), .DATA_WIDTH(8), .C_READ_LATENCY(1), .C_TIMEOUT(16)
  ) dut (
    .i_Clk       (clk),
    .i_Reset     (rst),
    .bus         (bus.master),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Register file model with one cycle of read latency.
  always @(posedge clk) if (bus.o_read_en) r_rd_addr <= bus.o_read_addr;
  assign bus.i_read_data = mem[r_rd_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.i_RX_DV   = 1'b1;
    bus.i_RX_Byte = b;
    tick();
    bus.i_RX_DV   = 1'b0;
    bus.i_RX_Byte = '0;
  endtask

  // Scoreboard: every strobe must match the head of its expected queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_write_en && bus.o_read_en) check("strobe_overlap", 32'd1, 32'd0);
      if (bus.o_write_en) begin
        check("wr_expected", 32'(exp_wr_q.size() != 0), 32'd1);
        if (exp_wr_q.size() != 0)
          check("wr_addr_data", 32'({bus.o_write_addr, bus.o_write_data}), 32'(exp_wr_q.pop_front()));
      end
      if (bus.o_read_en) begin
        check("rd_expected", 32'(exp_rd_q.size() != 0), 32'd1);
        if (exp_rd_q.size() != 0)
          check("rd_addr", 32'(bus.o_read_addr), 32'(exp_rd_q.pop_front()));
      end
      if (bus.o_TX_DV) begin
        check("tx_expected", 32'(exp_tx_q.size() != 0), 32'd1);
        if (exp_tx_q.size() != 0)
          check("tx_byte", 32'(bus.o_TX_Byte), 32'(exp_tx_q.pop_front()));
      end
    end
  end

  function automatic logic [31:0] all_outs();
    return 32'({bus.o_TX_DV, bus.o_TX_Byte, bus.o_write_en, bus.o_write_addr, bus.o_write_data,
                bus.o_read_en, bus.o_read_addr, bus.o_Busy, bus.o_Error});
  endfunction

  initial begin
    int bad;
    int seen;
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom_range(0, 255));
    mem[7] = 8'hC3;
    bus.i_RX_DV     = 1'b0;
    bus.i_RX_Byte   = '0;
    bus.i_TX_Active = 1'b0;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    check("reset_outputs", all_outs(), 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    tick();

    // 1: write 0x5A to register 3
    send_byte(8'h83);
    check("wr_cmd_busy", 32'(bus.o_Busy), 32'd1);
    check("wr_cmd_no_strobe", 32'(bus.o_write_en), 32'd0);
    tick();
    tick();
    exp_wr_q.push_back({5'd3, 8'h5A});
    send_byte(8'h5A);
    check("wr_strobe", 32'(bus.o_write_en), 32'd1);
    check("wr_addr", 32'(bus.o_write_addr), 32'd3);
    check("wr_data", 32'(bus.o_write_data), 32'h5A);
    tick();
    check("wr_strobe_one_cycle", 32'(bus.o_write_en), 32'd0);
    check("wr_done_idle", 32'(bus.o_Busy), 32'd0);

    // 2: read register 7, response over TX
    exp_rd_q.push_back(5'd7);
    exp_tx_q.push_back(8'hC3);
    send_byte(8'h07);
    check("rd_strobe", 32'(bus.o_read_en), 32'd1);
    check("rd_addr_direct", 32'(bus.o_read_addr), 32'd7);
    tick();
    check("rd_strobe_one_cycle", 32'(bus.o_read_en), 32'd0);
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      if (bus.o_TX_DV) seen = 1;
      else tick();
    end
    check("rd_tx_dv_seen", 32'(seen), 32'd1);
    check("rd_tx_byte", 32'(bus.o_TX_Byte), 32'hC3);
    tick();
    check("tx_dv_one_cycle", 32'(bus.o_TX_DV), 32'd0);
    check("tx_byte_held", 32'(bus.o_TX_Byte), 32'hC3);

    // 3: TX busy for 50 cycles, with a stray byte arriving meanwhile
    bus.i_TX_Active = 1'b1;
    exp_rd_q.push_back(5'd7);
    exp_tx_q.push_back(8'hC3);
    send_byte(8'h07);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (i == 10) begin
        send_byte(8'h83);
        check("stray_byte_error", 32'(bus.o_Error), 32'd1);
        check("stray_byte_busy", 32'(bus.o_Busy), 32'd1);
      end else begin
        tick();
      end
      if (bus.o_TX_DV) bad++;
    end
    check("tx_held_off", 32'(bad), 32'd0);
    bus.i_TX_Active = 1'b0;
    tick();
    check("tx_after_active_drop", 32'(bus.o_TX_DV), 32'd1);
    tick();
    check("tx_then_idle", 32'(bus.o_Busy), 32'd0);

    // 4: reserved bits set
    send_byte(8'hA1);
    check("bad_cmd_error", 32'(bus.o_Error), 32'd1);
    check("bad_cmd_busy", 32'(bus.o_Busy), 32'd0);
    check("bad_cmd_no_strobe", 32'({bus.o_write_en, bus.o_read_en}), 32'd0);
    tick();
    check("bad_cmd_error_pulse", 32'(bus.o_Error), 32'd0);
    check("bad_cmd_state", 32'(dbg_state), 32'd0);

    // 5: write timeout, error exactly 16 cycles after the command
    send_byte(8'h82);
    bad = 0;
    for (int k = 1; k <= 15; k++) begin
      if (bus.o_Error || !bus.o_Busy) bad++;
      if (k < 15) tick();
    end
    check("timeout_waiting", 32'(bad), 32'd0);
    tick();
    check("timeout_error", 32'(bus.o_Error), 32'd1);
    check("timeout_idle", 32'(bus.o_Busy), 32'd0);
    tick();
    check("timeout_error_pulse", 32'(bus.o_Error), 32'd0);
    exp_wr_q.push_back({5'd2, 8'h11});
    send_byte(8'h82);
    send_byte(8'h11);
    check("post_timeout_write", 32'({bus.o_write_en, bus.o_write_addr, bus.o_write_data}),
          32'({1'b1, 5'd2, 8'h11}));
    tick();

    // 6: reset in WAIT_DATA aborts the write
    send_byte(8'h85);
    tick();
    rst = 1'b1;
    tick();
    check("abort_outputs", all_outs(), 32'd0);
    rst = 1'b0;
    send_byte(8'h5A);
    check("abort_no_write", 32'(bus.o_write_en), 32'd0);
    check("abort_byte_as_cmd_error", 32'(bus.o_Error), 32'd1);
    repeat (4) tick();

    check("wr_queue_drained", 32'(exp_wr_q.size()), 32'd0);
    check("rd_queue_drained", 32'(exp_rd_q.size()), 32'd0);
    check("tx_queue_drained", 32'(exp_tx_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
